tap_slave_decoder: RTL and testbench
====================================

// Module: tap_slave_decoder
// PURPOSE
//  DUT-side consumer of the serial test-access link: tdi/tck/trstb in, tdo/tde out.
//  Oversamples the async tck/tdi/trstb on the system clock.
//  Checks an 8-bit unlock key, then decodes a config byte {length[4:0], mode[2:0]}.
//  Drives ATPG mode controls into the scan/test controller.
// PARAMETERS
//  KEY          8'h96  unlock key, shifted MSB first
//  SYNC_STAGES  2      synchroniser depth on tck/tdi/trstb (>=2)
// PORTS
//  clk          in   1  system clock; period <= tck_period/8
//  rst          in   1  asynchronous, active-high reset
//  tck          in   1  async test clock; data is captured on its rising edge
//  tdi          in   1  async serial data in, MSB first
//  trstb        in   1  async active-low TAP reset
//  tdo          out  1  serial readback data
//  tde          out  1  tdo drive enable
//  unlocked     out  1  key matched since last trstb/rst
//  key_err      out  1  wrong key received; sticky until trstb/rst
//  cfg_err      out  1  invalid config byte; sticky until trstb/rst
//  atpg_en      out  1  ATPG mode active
//  atpg_mode    out  3  committed mode: 3'b010 IDDQ, 3'b101 STUCK, 3'b110 DELAY
//  atpg_length  out  5  committed length field
// BEHAVIOUR
//  - rst, or synced trstb==0, clears everything: all outputs 0, state RST, bit counter 0, shift reg 0.
//    trstb low at any point mid-sequence aborts and clears.
//  - tck rise = synced tck 0->1. On that clk cycle, the synced tdi is shifted into sreg[7:0] (LSB in).
//    tdi sits >=4ns before the rise and is held for ~period, so this capture is safe.
//  - State and outputs register 1 clk after the detect cycle.
//  - FSM:
//    RST -> KEY on synced trstb 1.
//    KEY: count 8 rises.
//      8th rise, {sreg[6:0],tdi}==KEY -> CFG, unlocked=1.
//      Otherwise -> LOCK, key_err=1.
//    CFG: count 8 rises, latch cfg byte -> COMMIT.
//    COMMIT: next rise, bit value ignored.
//      Valid cfg -> ACTIVE: atpg_en=1, atpg_mode/atpg_length loaded.
//      Invalid cfg -> LOCK, cfg_err=1.
//    LOCK, ACTIVE: ignore further rises; left only via trstb low or rst.
//  - Cfg is valid iff mode is one of the three encodings above and length!=0.
//  - Only 8 key bits + 1 bit sent (key, then trailing 0): leaves unlocked=1, atpg_en=0, state CFG waiting.
//  - Bit counter is 3 bits, wraps 7->0 at each field boundary. Rises and trstb in the same clk: trstb wins.
//  - atpg_* change only on COMMIT; they hold values while ACTIVE.
// CONFIGURATION
//  TAP_READBACK_EN defined:
//    In ACTIVE, tde=1 and tdo presents {atpg_length,atpg_mode} MSB first.
//    Bit7 is presented on entry; advance one bit per synced tck fall; wrap after bit0.
//    tdo/tde return to 0 one clk after leaving ACTIVE.
//  Not defined: tdo=0, tde=0 always, no readback logic.
// STRUCTURE
//  Package tap_pkg holds:
//    - KEY_DEFAULT (8'h96)
//    - MODE_IDDQ/MODE_STUCK/MODE_DELAY localparams
//    - typedef enum logic[2:0] tap_state_e {RST,KEY,CFG,COMMIT,ACTIVE,LOCK}
//    - typedef struct packed {logic[4:0] length; logic[2:0] mode;} tap_cfg_t
//  Sub-module tap_sync: SYNC_STAGES-flop synchronisers for tck/tdi/trstb.
//    Outputs tck_rise/tck_fall pulses, tdi_s, trstb_s.
//    Its flops reset on rst: tck to 0, trstb to 0.
// TESTING
//  All sequences start with trstb low for 4 bits, then release; tck period 100ns.
//  1 key 8'h96 + cfg 8'h1D + 1 bit -> atpg_en=1, atpg_mode=3'b101, atpg_length=5'd3, errors 0.
//  2 key 8'h96 + single 0 bit -> unlocked=1, atpg_en=0, key_err=0, cfg_err=0.
//  3 key 8'h69, then cfg 8'h1D + 1 bit -> key_err=1, unlocked=0, atpg_en=0.
//  4 key 8'h96 + cfg 8'h18 (mode 000), and separately cfg 8'h02 (len 0) -> cfg_err=1, atpg_en=0.
//  5 trstb low after 4 cfg bits -> all outputs 0 within SYNC_STAGES+2 clk.
//    Then key 8'h96 + cfg 8'h12 + 1 bit -> atpg_en=1, mode=3'b010, length=5'd2.
//  6 (TAP_READBACK_EN) key 8'h96 + cfg 8'h22 + 1 bit.
//    Sample tdo at the next 8 tck rises -> 0,0,1,0,0,0,1,0, tde=1 throughout.
//    Then trstb low -> tde=0.

Source files
------------

// File: rtl/tap_pkg.sv
// tap_pkg: shared constants and types for the TAP slave decoder.
//   KEY_DEFAULT    default 8-bit unlock key
//   MODE_*         legal ATPG mode encodings
//   tap_state_e    decoder FSM states
//   tap_cfg_t      config byte layout {length[4:0], mode[2:0]}
//   cfg_valid()    legality test for a received config byte
package tap_pkg;

   localparam logic [7:0] KEY_DEFAULT = 8'h96;

   localparam logic [2:0] MODE_IDDQ  = 3'b010;
   localparam logic [2:0] MODE_STUCK = 3'b101;
   localparam logic [2:0] MODE_DELAY = 3'b110;

   typedef enum logic [2:0] {RST, KEY, CFG, COMMIT, ACTIVE, LOCK} tap_state_e;

   typedef struct packed {
      logic [4:0] length;
      logic [2:0] mode;
   } tap_cfg_t;

   function automatic logic cfg_valid(input tap_cfg_t c);
      return ((c.mode == MODE_IDDQ) || (c.mode == MODE_STUCK) || (c.mode == MODE_DELAY))
             && (c.length != 5'd0);
   endfunction

endpackage

// File: rtl/tap_sync.sv
// tap_sync: oversampling synchronisers for the async TAP pins.
//   clk, rst       system clock, async active-high reset
//   tck/tdi/trstb  raw async pins
//   tck_rise/fall  one-clk pulses on synced tck edges
//   tdi_s          synced tdi
//   trstb_s        synced trstb (resets low, so the decoder starts held in reset)
module tap_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic tck,
   input  logic tdi,
   input  logic trstb,
   output logic tck_rise,
   output logic tck_fall,
   output logic tdi_s,
   output logic trstb_s
);

   logic [SYNC_STAGES-1:0] tck_q, tdi_q, trstb_q;
   logic                   tck_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tck_q   <= '0;
         tdi_q   <= '0;
         trstb_q <= '0;
         tck_d   <= 1'b0;
      end else begin
         tck_q   <= {tck_q[SYNC_STAGES-2:0], tck};
         tdi_q   <= {tdi_q[SYNC_STAGES-2:0], tdi};
         trstb_q <= {trstb_q[SYNC_STAGES-2:0], trstb};
         tck_d   <= tck_q[SYNC_STAGES-1];
      end
   end

   assign tck_rise = tck_q[SYNC_STAGES-1] & ~tck_d;
   assign tck_fall = ~tck_q[SYNC_STAGES-1] & tck_d;
   assign tdi_s    = tdi_q[SYNC_STAGES-1];
   assign trstb_s  = trstb_q[SYNC_STAGES-1];

endmodule

// File: rtl/tap_slave_decoder.sv
// tap_slave_decoder: serial TAP consumer that unlocks on a key byte, then
// decodes a config byte {length, mode} into ATPG mode controls.
//   clk, rst            system clock, async active-high reset
//   tck, tdi, trstb     async serial link inputs (data captured on tck rise)
//   tdo, tde            serial readback data / drive enable
//   unlocked            key matched since last trstb/rst
//   key_err, cfg_err    sticky error flags, cleared by trstb/rst
//   atpg_en             ATPG mode active
//   atpg_mode/length    committed config fields
// Build option: define TAP_READBACK_EN to present {atpg_length, atpg_mode}
// on tdo while ACTIVE; otherwise tdo/tde are tied low.
module tap_slave_decoder
   import tap_pkg::*;
#(
   parameter logic [7:0] KEY         = KEY_DEFAULT,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tck,
   input  logic       tdi,
   input  logic       trstb,
   output logic       tdo,
   output logic       tde,
   output logic       unlocked,
   output logic       key_err,
   output logic       cfg_err,
   output logic       atpg_en,
   output logic [2:0] atpg_mode,
   output logic [4:0] atpg_length
);

   logic       tck_rise, tck_fall, tdi_s, trstb_s;
   tap_state_e state;
   logic [2:0] bitcnt;
   logic [7:0] sreg;
   tap_cfg_t   cfg_q;
   logic [7:0] byte_in;

   tap_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst      (rst),
      .tck      (tck),
      .tdi      (tdi),
      .trstb    (trstb),
      .tck_rise (tck_rise),
      .tck_fall (tck_fall),
      .tdi_s    (tdi_s),
      .trstb_s  (trstb_s)
   );

   // Byte as it will stand once the bit arriving this cycle is shifted in.
   assign byte_in = {sreg[6:0], tdi_s};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RST;
         bitcnt      <= 3'd0;
         sreg        <= 8'd0;
         cfg_q       <= '0;
         unlocked    <= 1'b0;
         key_err     <= 1'b0;
         cfg_err     <= 1'b0;
         atpg_en     <= 1'b0;
         atpg_mode   <= 3'd0;
         atpg_length <= 5'd0;
      end else if (!trstb_s) begin
         // TAP reset takes priority over a tck rise in the same cycle.
         state       <= RST;
         bitcnt      <= 3'd0;
         sreg        <= 8'd0;
         cfg_q       <= '0;
         unlocked    <= 1'b0;
         key_err     <= 1'b0;
         cfg_err     <= 1'b0;
         atpg_en     <= 1'b0;
         atpg_mode   <= 3'd0;
         atpg_length <= 5'd0;
      end else begin
         if (tck_rise) sreg <= byte_in;
         case (state)
            RST: state <= tap_pkg::KEY;
            tap_pkg::KEY: if (tck_rise) begin
               bitcnt <= bitcnt + 3'd1;
               if (bitcnt == 3'd7) begin
                  if (byte_in == KEY) begin
                     state    <= CFG;
                     unlocked <= 1'b1;
                  end else begin
                     state    <= LOCK;
                     key_err  <= 1'b1;
                  end
               end
            end
            CFG: if (tck_rise) begin
               bitcnt <= bitcnt + 3'd1;
               if (bitcnt == 3'd7) begin
                  cfg_q <= tap_cfg_t'(byte_in);
                  state <= COMMIT;
               end
            end
            COMMIT: if (tck_rise) begin
               // The committing bit's value is a don't-care.
               if (cfg_valid(cfg_q)) begin
                  state       <= ACTIVE;
                  atpg_en     <= 1'b1;
                  atpg_mode   <= cfg_q.mode;
                  atpg_length <= cfg_q.length;
               end else begin
                  state   <= LOCK;
                  cfg_err <= 1'b1;
               end
            end
            default: ;  // ACTIVE and LOCK hold until trstb/rst
         endcase
      end
   end

`ifdef TAP_READBACK_EN
   logic [2:0] rb_idx;
   logic       rb_armed;
   logic [7:0] rb_byte;

   // The first synced fall seen in ACTIVE closes the committing bit, so it
   // does not shift; bit7 is then held for a full tck period and the host
   // samples each bit on the following rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rb_idx   <= 3'd0;
         rb_armed <= 1'b0;
      end else if (state != ACTIVE) begin
         rb_idx   <= 3'd0;
         rb_armed <= 1'b0;
      end else if (tck_fall) begin
         if (!rb_armed) rb_armed <= 1'b1;
         else           rb_idx   <= rb_idx + 3'd1;
      end
   end

   assign rb_byte = {atpg_length, atpg_mode};
   assign tde     = (state == ACTIVE);
   assign tdo     = tde & rb_byte[3'd7 - rb_idx];
`else
   logic rb_unused;
   assign rb_unused = tck_fall;
   assign tdo       = 1'b0;
   assign tde       = 1'b0;
`endif

endmodule

// File: tb/tb_tap_slave_decoder.sv
module tb_tap_slave_decoder;

   localparam int SYNC_STAGES = 2;

   logic clk = 1'b0;
   logic rst, tck, tdi, trstb;
   logic tdo, tde, unlocked, key_err, cfg_err, atpg_en;
   logic [2:0] atpg_mode;
   logic [4:0] atpg_length;

   always #5 clk = ~clk;

   tap_slave_decoder #(.KEY(8'h96), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk(clk), .rst(rst), .tck(tck), .tdi(tdi), .trstb(trstb),
      .tdo(tdo), .tde(tde), .unlocked(unlocked), .key_err(key_err),
      .cfg_err(cfg_err), .atpg_en(atpg_en), .atpg_mode(atpg_mode),
      .atpg_length(atpg_length)
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model: the bit history since the last TAP reset.
   int         m_n;      // bits received
   logic [7:0] m_key;    // first 8 bits
   logic [7:0] m_cfg;    // next 8 bits
   int         m_falls;  // tck falls since the committing bit
   logic       settled;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic m_clear();
      m_n = 0; m_key = 8'd0; m_cfg = 8'd0; m_falls = 0;
   endtask

   task automatic m_rise(input logic b);
      m_n++;
      if (m_n <= 8)       m_key = {m_key[6:0], b};
      else if (m_n <= 16) m_cfg = {m_cfg[6:0], b};
   endtask

   task automatic m_fall();
      if (m_n >= 17) m_falls++;
   endtask

   // Compare process: every settled clk, outputs must match the rules.
   always @(negedge clk) begin
      if (settled && !rst) begin
         logic e_unl, e_kerr, e_commit, e_valid, e_en, e_cerr, e_tde, e_tdo;
         logic [2:0] e_mode, idx;
         logic [4:0] e_len;
         e_unl    = (m_n >= 8) && (m_key == 8'h96);
         e_kerr   = (m_n >= 8) && (m_key != 8'h96);
         e_commit = e_unl && (m_n >= 17);
         e_valid  = (m_cfg[2:0] == 3'b010 || m_cfg[2:0] == 3'b101 || m_cfg[2:0] == 3'b110)
                    && (m_cfg[7:3] != 5'd0);
         e_en     = e_commit && e_valid;
         e_cerr   = e_commit && !e_valid;
         e_mode   = e_en ? m_cfg[2:0] : 3'd0;
         e_len    = e_en ? m_cfg[7:3] : 5'd0;
         idx      = (m_falls == 0) ? 3'd0 : 3'((m_falls - 1) % 8);
`ifdef TAP_READBACK_EN
         e_tde    = e_en;
         e_tdo    = e_en & m_cfg[3'd7 - idx];
`else
         e_tde    = 1'b0;
         e_tdo    = 1'b0;
`endif
         chk("unlocked", {7'd0, unlocked}, {7'd0, e_unl});
         chk("key_err", {7'd0, key_err}, {7'd0, e_kerr});
         chk("cfg_err", {7'd0, cfg_err}, {7'd0, e_cerr});
         chk("atpg_en", {7'd0, atpg_en}, {7'd0, e_en});
         chk("atpg_mode", {5'd0, atpg_mode}, {5'd0, e_mode});
         chk("atpg_length", {3'd0, atpg_length}, {3'd0, e_len});
         chk("tde", {7'd0, tde}, {7'd0, e_tde});
         chk("tdo", {7'd0, tdo}, {7'd0, e_tdo});
      end
   end

   // One tck period (100ns): tdi set 5ns before the rise.
   task automatic send_bit(input logic b);
      tdi = b;
      #5;
      tck = 1'b1; m_rise(b); settled = 1'b0;
      #40 settled = 1'b1;
      #5;
      tck = 1'b0; m_fall(); settled = 1'b0;
      #40 settled = 1'b1;
      #10;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic tap_reset();
      trstb = 1'b0; settled = 1'b0; m_clear();
      #40 settled = 1'b1;
      #360;
      trstb = 1'b1; settled = 1'b0;
      #40 settled = 1'b1;
      #60;
   endtask

   // Hand-computed expectations that pin the model.
   task automatic lit(input string tag, input logic en, input logic [2:0] md,
                      input logic [4:0] ln, input logic ul, input logic ke, input logic ce);
      chk({tag, ".atpg_en"}, {7'd0, atpg_en}, {7'd0, en});
      chk({tag, ".atpg_mode"}, {5'd0, atpg_mode}, {5'd0, md});
      chk({tag, ".atpg_length"}, {3'd0, atpg_length}, {3'd0, ln});
      chk({tag, ".unlocked"}, {7'd0, unlocked}, {7'd0, ul});
      chk({tag, ".key_err"}, {7'd0, key_err}, {7'd0, ke});
      chk({tag, ".cfg_err"}, {7'd0, cfg_err}, {7'd0, ce});
   endtask

   initial begin
      logic [7:0] rb;
      rst = 1'b1; tck = 1'b0; tdi = 1'b0; trstb = 1'b0; settled = 1'b0;
      m_clear();
      repeat (3) @(posedge clk);
      #1;
      lit("reset", 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("reset.tdo", {7'd0, tdo}, 8'd0);
      chk("reset.tde", {7'd0, tde}, 8'd0);
      rst = 1'b0;
      #20;

      // 1: valid STUCK config
      tap_reset(); send_byte(8'h96); send_byte(8'h1D); send_bit(1'b0);
      lit("t1", 1'b1, 3'b101, 5'd3, 1'b1, 1'b0, 1'b0);

      // 2: key plus one bit leaves decoder waiting in CFG
      tap_reset(); send_byte(8'h96); send_bit(1'b0);
      lit("t2", 1'b0, 3'd0, 5'd0, 1'b1, 1'b0, 1'b0);

      // 3: wrong key locks out the following config
      tap_reset(); send_byte(8'h69); send_byte(8'h1D); send_bit(1'b0);
      lit("t3", 1'b0, 3'd0, 5'd0, 1'b0, 1'b1, 1'b0);

      // 4: illegal mode, then zero length
      tap_reset(); send_byte(8'h96); send_byte(8'h18); send_bit(1'b0);
      lit("t4a", 1'b0, 3'd0, 5'd0, 1'b1, 1'b0, 1'b1);
      tap_reset(); send_byte(8'h96); send_byte(8'h02); send_bit(1'b0);
      lit("t4b", 1'b0, 3'd0, 5'd0, 1'b1, 1'b0, 1'b1);

      // 5: abort mid-config, outputs clear within SYNC_STAGES+2 clk
      tap_reset(); send_byte(8'h96);
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
      trstb = 1'b0; settled = 1'b0; m_clear();
      repeat (SYNC_STAGES + 2) @(posedge clk);
      #1;
      lit("t5abort", 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      settled = 1'b1;
      #300;
      trstb = 1'b1; settled = 1'b0;
      #40 settled = 1'b1;
      #60;
      send_byte(8'h96); send_byte(8'h12); send_bit(1'b0);
      lit("t5", 1'b1, 3'b010, 5'd2, 1'b1, 1'b0, 1'b0);

`ifdef TAP_READBACK_EN
      // 6: readback of {length, mode} = 8'h22, sampled just before each rise
      tap_reset(); send_byte(8'h96); send_byte(8'h22); send_bit(1'b0);
      rb = 8'b0010_0010;
      for (int i = 0; i < 8; i++) begin
         chk("t6.tdo", {7'd0, tdo}, {7'd0, rb[7-i]});
         chk("t6.tde", {7'd0, tde}, 8'd1);
         send_bit(1'b0);
      end
      trstb = 1'b0; settled = 1'b0; m_clear();
      repeat (SYNC_STAGES + 2) @(posedge clk);
      #1;
      chk("t6.tde_off", {7'd0, tde}, 8'd0);
      chk("t6.tdo_off", {7'd0, tdo}, 8'd0);
      settled = 1'b1;
      #100;
`else
      rb = 8'd0;
      chk("norb.tde", {7'd0, tde}, rb);
      chk("norb.tdo", {7'd0, tdo}, rb);
`endif

      settled = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
